// File: rtl/systolic_feeder_if.sv
// Operand beat channel into the systolic feeder: one A column and one B row per beat.
interface systolic_feeder_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 4
) ();
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [N*DATA_WIDTH-1:0] a_col_i;
    logic [N*DATA_WIDTH-1:0] b_row_i;

    modport master (output in_valid_i, a_col_i, b_row_i, input in_ready_o);
    modport slave  (input in_valid_i, a_col_i, b_row_i, output in_ready_o);
endinterface

// File: rtl/systolic_feeder.sv
// Feeds K beats of A columns / B rows into an N x N systolic array with per-lane skew,
// then drains zeros long enough for the far corner PE to finish accumulating.
module systolic_feeder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [7:0]            k_len_i,
    systolic_feeder_if.slave      in_if,
    output logic [DATA_WIDTH-1:0] data_a_0_o,
    output logic [DATA_WIDTH-1:0] data_a_1_o,
    output logic [DATA_WIDTH-1:0] data_a_2_o,
    output logic [DATA_WIDTH-1:0] data_a_3_o,
    output logic [DATA_WIDTH-1:0] data_b_0_o,
    output logic [DATA_WIDTH-1:0] data_b_1_o,
    output logic [DATA_WIDTH-1:0] data_b_2_o,
    output logic [DATA_WIDTH-1:0] data_b_3_o,
    output logic                  acc_en_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int unsigned DRAIN_LEN = 3 * N - 2;
    localparam int unsigned DCW       = $clog2(DRAIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

    state_e           state_q, state_d;
    logic [7:0]       klen_q, klen_d;
    logic [7:0]       beat_q, beat_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             ready_q, ready_d;
    logic             acc_en_q, acc_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

    logic [DATA_WIDTH-1:0] a_out [N];
    logic [DATA_WIDTH-1:0] b_out [N];

    assign accept = in_if.in_valid_i & ready_q;

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                beat_d  = '0;
                drain_d = '0;
                if (start_i) begin
                    if (k_len_i != 8'd0) begin
                        klen_d  = k_len_i;
                        state_d = STREAM;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    if (8'(beat_q + 8'd1) == klen_q) begin
                        beat_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        beat_d = 8'(beat_q + 8'd1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(DRAIN_LEN - 1)) begin
                    drain_d = '0;
                    state_d = DONE;
                end else begin
                    drain_d = DCW'(drain_q + DCW'(1));
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d  = (state_d == STREAM);
        acc_en_d = (state_d == STREAM) || (state_d == DRAIN);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            klen_q   <= '0;
            beat_q   <= '0;
            drain_q  <= '0;
            ready_q  <= 1'b0;
            acc_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            klen_q   <= klen_d;
            beat_q   <= beat_d;
            drain_q  <= drain_d;
            ready_q  <= ready_d;
            acc_en_q <= acc_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Lane i is an (i+1)-deep shift register; non-accepting cycles shift in zero bubbles
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int unsigned W = (i + 1) * DATA_WIDTH;
        logic [W-1:0]          a_sr_q, a_sr_d;
        logic [W-1:0]          b_sr_q, b_sr_d;
        logic [DATA_WIDTH-1:0] a_in, b_in;

        always_comb begin
            a_in   = accept ? in_if.a_col_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            b_in   = accept ? in_if.b_row_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            a_sr_d = W'({a_sr_q, a_in});
            b_sr_d = W'({b_sr_q, b_in});
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                a_sr_q <= '0;
                b_sr_q <= '0;
            end else begin
                a_sr_q <= a_sr_d;
                b_sr_q <= b_sr_d;
            end
        end

        assign a_out[i] = a_sr_q[W-1 -: DATA_WIDTH];
        assign b_out[i] = b_sr_q[W-1 -: DATA_WIDTH];
    end

    assign in_if.in_ready_o = ready_q;
    assign acc_en_o         = acc_en_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

    assign data_a_0_o = a_out[0];
    assign data_a_1_o = a_out[1];
    assign data_a_2_o = a_out[2];
    assign data_a_3_o = a_out[3];
    assign data_b_0_o = b_out[0];
    assign data_b_1_o = b_out[1];
    assign data_b_2_o = b_out[2];
    assign data_b_3_o = b_out[3];
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, element width in bits, signed.
REQ-002 SHALL have parameter N, default 4, array dimension; lanes per operand.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port start_i, input, 1, single-cycle request to begin one matrix product.
REQ-006 SHALL have port k_len_i, input, 8, number of K beats, sampled with start_i.
REQ-007 SHALL have port in_valid_i, input, 1, beat present on a_col_i/b_row_i.
REQ-008 SHALL have port in_ready_o, output, 1, feeder accepts a beat this cycle.
REQ-009 SHALL have port a_col_i, input, N*DATA_WIDTH, column k of A; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port b_row_i, input, N*DATA_WIDTH, row k of B; same lane packing.
REQ-011 SHALL have ports data_a_0_o..data_a_3_o, output, DATA_WIDTH each, skewed A row streams to the array.
REQ-012 SHALL have ports data_b_0_o..data_b_3_o, output, DATA_WIDTH each, skewed B column streams to the array.
REQ-013 SHALL have port acc_en_o, output, 1, accumulate enable to the array.
REQ-014 SHALL have ports busy_o and done_o, output, 1 each: operation in progress; one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM, DRAIN, DONE.
REQ-016 IDLE: start_i=1 with k_len_i>0 -> STREAM, latch k_len; start_i=1 with k_len_i=0 -> DRAIN; otherwise stay.
REQ-017 start_i outside IDLE SHALL be ignored with no effect on the current operation.
REQ-018 in_ready_o SHALL be 1 only in STREAM; beat accepted on edge where in_valid_i and in_ready_o are both 1.
REQ-019 STREAM SHALL count accepted beats; the edge accepting beat k_len SHALL move to DRAIN.
REQ-020 Element of lane i from a beat accepted at edge t SHALL appear on data_a_i_o / data_b_i_o from edge t+i until edge t+i+1 (registered outputs, i-stage skew delay).
REQ-021 Any cycle in which no beat is accepted SHALL inject zero into the skew input of every lane (bubbles contribute 0 products, preserve alignment).
REQ-022 DRAIN SHALL last exactly 3*N-2 cycles (10 at N=4), injecting zeros, then go to DONE.
REQ-023 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-024 acc_en_o SHALL be 1 exactly in cycles where state is STREAM or DRAIN.
REQ-025 busy_o SHALL be 1 in STREAM, DRAIN and DONE.
REQ-026 Data SHALL pass through unmodified: no rounding, saturation or sign change.
REQ-027 k_len=255 SHALL be supported; beat counter SHALL not wrap before reaching k_len.

Reset
REQ-028 rstn=0 at a rising edge SHALL force IDLE, clear beat and drain counters, and zero all skew registers.
REQ-029 During and after reset, all data outputs, acc_en_o, in_ready_o, busy_o and done_o SHALL be 0.
REQ-030 Reset mid-STREAM or mid-DRAIN SHALL abort without a done_o pulse; the first post-reset start_i is honoured normally.

Verification
REQ-031 Reset then idle 5 cycles -> all outputs 0, in_ready_o=0.
REQ-032 start, k_len=4, A columns and B rows 1..16 row-major, in_valid held 1 -> lane i of beat k at edge t_k+i; acc_en_o high 14 cycles; done_o one pulse; array result equals A*B.
REQ-033 Same as REQ-032 with in_valid_i low on alternate cycles -> zero bubbles on all lanes; same array result; STREAM lasts 8 cycles.
REQ-034 start with k_len=0 -> no in_ready_o, 10 cycles acc_en_o=1 with zero data, then done_o pulse.
REQ-035 start_i pulsed again during STREAM with k_len=9 -> ignored; operation completes after original 4 beats.
REQ-036 rstn=0 during DRAIN cycle 3 -> next edge outputs 0, no done_o; new start k_len=2 completes normally.
